writeback_arbiter: RTL and testbench

Merges register writebacks from the single-cycle ALU path and the long-latency path (multiply/divide, loads) onto the register file's one write port. ALU results have priority. Long results queue in a small FIFO with a valid/ready handshake. A starvation guard periodically stalls the pipeline so queued results drain. The block sits between the MEM/WB pipeline register plus the MULDIV unit and the register file's WriteReg1/WriteData1/Write1 inputs, and exports a pending-destination mask to the hazard unit.

---
 rtl/writeback_arbiter_if.sv | 23 ++
 rtl/writeback_arbiter.sv | 112 +++++++++++
 tb/tb_writeback_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: ALU/long-path writeback requests and register-file write port bundle
interface writeback_arbiter_if;
  logic        AluValid;
  logic [4:0]  AluReg;
  logic [31:0] AluData;
  logic        LongValid;
  logic        LongReady;
  logic [4:0]  LongReg;
  logic [31:0] LongData;
  logic [4:0]  WriteReg1;
  logic [31:0] WriteData1;
  logic        Write1;
  logic        Stall;
  logic [31:0] PendingMask;
  modport master (
    output AluValid, AluReg, AluData, LongValid, LongReg, LongData,
    input  LongReady, WriteReg1, WriteData1, Write1, Stall, PendingMask
  );
  modport slave (
    input  AluValid, AluReg, AluData, LongValid, LongReg, LongData,
    output LongReady, WriteReg1, WriteData1, Write1, Stall, PendingMask
  );
endinterface

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU and long-latency writebacks onto one register-file write port; WB_TRACE_EN enables a commit trace
module writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input logic                CLK,
  input logic                RESET,
  writeback_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];
  logic [4:0]       fifo_reg  [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [DEPTH-1:0] fifo_vld;
  logic [DEPTH-1:0] push_sel;
  logic [DEPTH-1:0] pop_sel;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic [3:0]       starve;
  logic [3:0]       starve_nxt;
  logic             stall;
  logic             empty;
  logic             alu_win;
  logic             push;
  logic             pop;
  logic [4:0]       head_reg;
  logic [31:0]      head_data;
  logic [4:0]       write_reg;
  logic [31:0]      write_data;
  logic             write1;
  logic [31:0]      pending;

  assign empty         = count == '0;
  assign bus.LongReady = count != FULL;
  assign alu_win       = !stall && bus.AluValid;
  assign pop           = !alu_win && !empty;
  assign push          = bus.LongValid && bus.LongReady && bus.LongReg != 5'd0;
  assign head_reg      = fifo_reg[rd_ptr];
  assign head_data     = fifo_data[rd_ptr];
  assign push_sel      = push ? {{(DEPTH-1){1'b0}}, 1'b1} << wr_ptr : '0;
  assign pop_sel       = pop ? {{(DEPTH-1){1'b0}}, 1'b1} << rd_ptr : '0;
  assign starve_nxt    = (empty || pop) ? 4'd0 : starve + 4'd1;

  assign bus.WriteReg1   = write_reg;
  assign bus.WriteData1  = write_data;
  assign bus.Write1      = write1;
  assign bus.Stall       = stall;
  assign bus.PendingMask = pending;

  // capture pushed payload; entry validity is tracked separately so storage needs no reset
  always_ff @(posedge CLK)
    if (push) begin
      fifo_reg[wr_ptr]  <= bus.LongReg;
      fifo_data[wr_ptr] <= bus.LongData;
    end

  // circular pointers, occupancy and per-entry valid bits
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fifo_vld <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count    <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      fifo_vld <= (fifo_vld & ~pop_sel) | push_sel;
    end

  // register the arbitration winner and run the starvation guard that forces a drain cycle
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      write1     <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      stall      <= 1'b0;
      starve     <= '0;
    end else begin
      write1 <= alu_win ? bus.AluReg != 5'd0 : pop && head_reg != 5'd0;
      if (alu_win || pop) begin
        write_reg  <= alu_win ? bus.AluReg : head_reg;
        write_data <= alu_win ? bus.AluData : head_data;
      end
      starve <= starve_nxt;
      stall  <= starve_nxt == LIMIT;
    end

  // flag every register with a queued result so the hazard unit can hold dependent issue
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++)
      if (fifo_vld[i]) pending[fifo_reg[i]] = 1'b1;
    pending[0] = 1'b0;
  end

`ifdef WB_TRACE_EN
  // commit trace plus a sanity check on the push handshake
  always_ff @(posedge CLK)
    if (RESET) begin
      if (alu_win && bus.AluReg != 5'd0)
        $display("WB:%s Reg[%d]=%x", "ALU", bus.AluReg, bus.AluData);
      else if (pop && head_reg != 5'd0)
        $display("WB:%s Reg[%d]=%x", "LNG", head_reg, head_data);
      if (bus.LongValid && bus.LongReady && count == FULL)
        $display("WB: error, push accepted while full");
    end
`else
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: randomized and directed checks against a queue-based writeback model
module tb_writeback_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 3;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  writeback_arbiter_if bus();
  writeback_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus.slave)
  );
  always #5 CLK = ~CLK;

  typedef struct { logic [4:0] r; logic [31:0] d; } ent_t;
  ent_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        m_stall;
  logic        m_w1;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;
  int          m_starve;

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (q[i]) m[q[i].r] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    q.delete();
    m_stall = 1'b0;
    m_w1 = 1'b0;
    m_wr = '0;
    m_wd = '0;
    m_starve = 0;
  endtask

  task automatic cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    int   n = q.size();
    bit   ready = n != DEPTH;
    bit   popped = 1'b0;
    ent_t e;
    bus.AluValid = av; bus.AluReg = ar; bus.AluData = ad;
    bus.LongValid = lv; bus.LongReg = lr; bus.LongData = ld;
    if (!m_stall && av) begin
      m_w1 = ar != 5'd0; m_wr = ar; m_wd = ad;
    end else if (n != 0) begin
      e = q.pop_front();
      popped = 1'b1;
      m_w1 = e.r != 5'd0; m_wr = e.r; m_wd = e.d;
    end else m_w1 = 1'b0;
    m_starve = (n == 0 || popped) ? 0 : m_starve + 1;
    m_stall = m_starve == LIMIT;
    if (lv && ready && lr != 5'd0) begin
      e.r = lr; e.d = ld;
      q.push_back(e);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_reset();
    bus.AluValid = 0; bus.AluReg = 0; bus.AluData = 0;
    bus.LongValid = 0; bus.LongReg = 0; bus.LongData = 0;
    model_reset();
    #2 RESET = 1'b0;
    #3;
    vectors++;
    if ({bus.Write1, bus.WriteReg1, bus.WriteData1, bus.Stall} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got w1=%b reg=%0d data=%h stall=%b want all 0",
               bus.Write1, bus.WriteReg1, bus.WriteData1, bus.Stall);
    end
    vectors++;
    if (bus.LongReady !== 1'b1) begin
      miscompares++; $display("FAIL reset_ready: got %b want 1", bus.LongReady);
    end
    vectors++;
    if (bus.PendingMask !== 32'h0) begin
      miscompares++; $display("FAIL reset_mask: got %h want 0", bus.PendingMask);
    end
    @(negedge CLK);
    RESET = 1'b1;
    idle();
    vectors++;
    if (bus.Write1 !== 1'b0 || bus.Stall !== 1'b0) begin
      miscompares++; $display("FAIL idle_after_reset: got w1=%b stall=%b want 0 0", bus.Write1, bus.Stall);
    end
  endtask

  task automatic test_alu_basic();
    cycle(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    vectors++;
    if (bus.Write1 !== 1'b1 || bus.WriteReg1 !== 5'd5 || bus.WriteData1 !== 32'h1234) begin
      miscompares++;
      $display("FAIL alu_write: got w1=%b reg=%0d data=%h want 1 5 00001234",
               bus.Write1, bus.WriteReg1, bus.WriteData1);
    end
    idle();
    vectors++;
    if (bus.Write1 !== 1'b0) begin
      miscompares++; $display("FAIL alu_one_shot: got w1=%b want 0", bus.Write1);
    end
  endtask

  task automatic test_zero_reg();
    cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
    vectors++;
    if (bus.Write1 !== 1'b0) begin
      miscompares++; $display("FAIL alu_zero_reg: got w1=%b want 0", bus.Write1);
    end
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
    vectors++;
    if (bus.PendingMask !== 32'h0 || bus.LongReady !== 1'b1) begin
      miscompares++;
      $display("FAIL long_zero_reg: got mask=%h ready=%b want 0 1", bus.PendingMask, bus.LongReady);
    end
    idle();
    vectors++;
    if (bus.Write1 !== 1'b0) begin
      miscompares++; $display("FAIL long_zero_not_queued: got w1=%b want 0", bus.Write1);
    end
  endtask

  task automatic test_long_only();
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hA);
    vectors++;
    if (bus.PendingMask !== 32'h80 || bus.Write1 !== 1'b0) begin
      miscompares++;
      $display("FAIL long_queued: got mask=%h w1=%b want 00000080 0", bus.PendingMask, bus.Write1);
    end
    idle();
    vectors++;
    if (bus.Write1 !== 1'b1 || bus.WriteReg1 !== 5'd7 || bus.WriteData1 !== 32'hA || bus.PendingMask !== 32'h0) begin
      miscompares++;
      $display("FAIL long_commit: got w1=%b reg=%0d data=%h mask=%h want 1 7 0000000a 0",
               bus.Write1, bus.WriteReg1, bus.WriteData1, bus.PendingMask);
    end
  endtask

  task automatic test_full_fifo();
    int   got = 0;
    logic prev_stall;
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 5'(16 + i), 32'(32'h5000 + i), 1'b1, 5'(i), 32'(32'h100 + i));
      vectors++;
      if (bus.LongReady !== (i < 4)) begin
        miscompares++; $display("FAIL full_ready_%0d: got %b want %b", i, bus.LongReady, i < 4);
      end
    end
    vectors++;
    if (bus.Stall !== 1'b1 || bus.PendingMask !== 32'h1E) begin
      miscompares++;
      $display("FAIL full_stall_rise: got stall=%b mask=%h want 1 0000001e", bus.Stall, bus.PendingMask);
    end
    for (int c = 0; c < 24 && got < 4; c++) begin
      prev_stall = bus.Stall;
      cycle(1'b1, 5'd20, 32'h6000, 1'b0, 5'd0, 32'd0);
      vectors++;
      if (bus.Stall !== m_stall) begin
        miscompares++; $display("FAIL full_stall_c%0d: got %b want %b", c, bus.Stall, m_stall);
      end
      if (bus.Write1 === 1'b1 && bus.WriteData1[31:8] == 24'h1) begin
        got++;
        vectors++;
        if (bus.WriteReg1 !== 5'(got) || bus.WriteData1 !== 32'(32'h100 + got) || prev_stall !== 1'b1) begin
          miscompares++;
          $display("FAIL full_order_%0d: got reg=%0d data=%h in_stall=%b want %0d %h 1",
                   got, bus.WriteReg1, bus.WriteData1, prev_stall, got, 32'h100 + got);
        end
      end
    end
    vectors++;
    if (got != 4) begin
      miscompares++; $display("FAIL full_drain: got %0d long commits want 4", got);
    end
  endtask

  task automatic test_simultaneous();
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
    vectors++;
    if (bus.PendingMask !== 32'h200) begin
      miscompares++; $display("FAIL simul_first: got mask=%h want 00000200", bus.PendingMask);
    end
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hAA);
    vectors++;
    if (bus.Write1 !== 1'b1 || bus.WriteReg1 !== 5'd9 || bus.WriteData1 !== 32'h99 || bus.PendingMask !== 32'h400) begin
      miscompares++;
      $display("FAIL simul_pushpop: got w1=%b reg=%0d data=%h mask=%h want 1 9 00000099 00000400",
               bus.Write1, bus.WriteReg1, bus.WriteData1, bus.PendingMask);
    end
    idle();
    vectors++;
    if (bus.Write1 !== 1'b1 || bus.WriteReg1 !== 5'd10 || bus.PendingMask !== 32'h0) begin
      miscompares++;
      $display("FAIL simul_second: got w1=%b reg=%0d mask=%h want 1 10 0",
               bus.Write1, bus.WriteReg1, bus.PendingMask);
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 5'd21, 32'h21, 1'b1, 5'd11, 32'hB1);
    cycle(1'b1, 5'd22, 32'h22, 1'b1, 5'd12, 32'hB2);
    cycle(1'b1, 5'd23, 32'h23, 1'b1, 5'd13, 32'hB3);
    cycle(1'b1, 5'd24, 32'h24, 1'b0, 5'd0, 32'd0);
    vectors++;
    if (bus.Stall !== 1'b1 || bus.PendingMask !== 32'h3800) begin
      miscompares++;
      $display("FAIL areset_setup: got stall=%b mask=%h want 1 00003800", bus.Stall, bus.PendingMask);
    end
    #2 RESET = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({bus.Write1, bus.WriteReg1, bus.WriteData1, bus.Stall} !== '0 || bus.PendingMask !== 32'h0 || bus.LongReady !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_clear: got w1=%b reg=%0d data=%h stall=%b mask=%h ready=%b want 0 0 0 0 0 1",
               bus.Write1, bus.WriteReg1, bus.WriteData1, bus.Stall, bus.PendingMask, bus.LongReady);
    end
    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      vectors++;
      if (bus.Write1 !== 1'b0 || bus.PendingMask !== 32'h0) begin
        miscompares++;
        $display("FAIL areset_stale_%0d: got w1=%b mask=%h want 0 0", i, bus.Write1, bus.PendingMask);
      end
    end
  endtask

  task automatic test_random();
    logic        av, lv;
    logic [4:0]  ar, lr;
    logic [31:0] ad, ld;
    for (int i = 0; i < 500; i++) begin
      av = $urandom_range(0, 99) < 60;
      ar = 5'($urandom_range(0, 31));
      ad = $urandom;
      lv = $urandom_range(0, 99) < 50;
      lr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ld = $urandom;
      cycle(av, ar, ad, lv, lr, ld);
      vectors++;
      if (bus.Write1 !== m_w1) begin
        miscompares++; $display("FAIL rand_w1_%0d: got %b want %b", i, bus.Write1, m_w1);
      end
      if (m_w1) begin
        vectors++;
        if (bus.WriteReg1 !== m_wr || bus.WriteData1 !== m_wd) begin
          miscompares++;
          $display("FAIL rand_commit_%0d: got reg=%0d data=%h want %0d %h", i, bus.WriteReg1, bus.WriteData1, m_wr, m_wd);
        end
      end
      vectors++;
      if (bus.Stall !== m_stall) begin
        miscompares++; $display("FAIL rand_stall_%0d: got %b want %b", i, bus.Stall, m_stall);
      end
      vectors++;
      if (bus.LongReady !== (q.size() != DEPTH)) begin
        miscompares++; $display("FAIL rand_ready_%0d: got %b want %b", i, bus.LongReady, q.size() != DEPTH);
      end
      vectors++;
      if (bus.PendingMask !== model_mask()) begin
        miscompares++; $display("FAIL rand_mask_%0d: got %h want %h", i, bus.PendingMask, model_mask());
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_zero_reg();
    test_long_only();
    test_full_fifo();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
